// File: rtl/xgmii_blk_assembler_pkg.sv
// Shared XGMII block-assembly definitions: control symbols, transfer-count helpers, FSM state and block types.
// Used by xgmii_blk_assembler and xgmii_ctrl_checker (XGMII_BLK_ERR_CHECK_EN).
package xgmii_blk_assembler_pkg;

    localparam logic [7:0] SYM_IDLE  = 8'h07;
    localparam logic [7:0] SYM_START = 8'hFB;
    localparam logic [7:0] SYM_TERM  = 8'hFD;
    localparam logic [7:0] SYM_ERR   = 8'hFE;

    // Transfers per 64-bit block for a given XGMII width.
    function automatic int unsigned n_trans(input int unsigned w_data);
        return 64 / w_data;
    endfunction

    // Transfer-counter width; never narrower than one bit, even when a block is one transfer.
    function automatic int unsigned w_trans(input int unsigned w_data);
        return (64 / w_data > 1) ? $clog2(64 / w_data) : 1;
    endfunction

    function automatic logic is_legal_ctrl(input logic [7:0] sym);
        return (sym == SYM_IDLE) || (sym == SYM_START) || (sym == SYM_TERM) || (sym == SYM_ERR);
    endfunction

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } blk_asm_state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  ctrl;
    } blk_t;

endpackage

// File: rtl/xgmii_ctrl_checker.sv
// Per-lane XGMII control-symbol validity check; illegal control bytes are replaced by the error symbol.
// Only instantiated when XGMII_BLK_ERR_CHECK_EN is defined.
module xgmii_ctrl_checker
    import xgmii_blk_assembler_pkg::*;
#(
    parameter int unsigned N_CHANNELS = 4
) (
    input  logic [8*N_CHANNELS-1:0] i_data,
    input  logic [N_CHANNELS-1:0]   i_ctrl,
    output logic [8*N_CHANNELS-1:0] o_data,
    output logic [N_CHANNELS-1:0]   o_err
);

    always_comb begin
        o_data = i_data;
        o_err  = '0;
        for (int unsigned n = 0; n < N_CHANNELS; n++) begin
            if (i_ctrl[n] && !is_legal_ctrl(i_data[8*n +: 8])) begin
                o_data[8*n +: 8] = SYM_ERR;
                o_err[n]         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xgmii_blk_assembler.sv
// Collects 16/32/64-bit XGMII transfers into START-aligned 64-bit blocks with per-byte control flags.
// Defining XGMII_BLK_ERR_CHECK_EN replaces illegal control bytes with ERR and raises o_blk_err.
module xgmii_blk_assembler
    import xgmii_blk_assembler_pkg::*;
#(
    parameter  int unsigned W_DATA     = 32,
    localparam int unsigned N_CHANNELS = W_DATA / 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [W_DATA-1:0]     i_xgmii_data,
    input  logic [N_CHANNELS-1:0] i_xgmii_ctrl,
    input  logic                  i_valid,
    output logic [63:0]           o_blk_data,
    output logic [7:0]            o_blk_ctrl,
    output logic                  o_blk_valid,
    output logic                  o_blk_err,
    output logic                  o_locked,
    output logic [7:0]            o_misalign_cnt
);

    localparam int unsigned     N_TRANS = n_trans(W_DATA);
    localparam int unsigned     W_TRANS = w_trans(W_DATA);
    localparam logic [W_TRANS-1:0] LAST = W_TRANS'(N_TRANS - 1);

    blk_asm_state_t        state;
    logic [W_TRANS-1:0]    cnt;
    logic [W_TRANS-1:0]    wr_slot;
    logic [W_TRANS-1:0]    cnt_nxt;
    blk_t                  stg;
    blk_t                  mrg;
    logic                  stg_err;
    logic                  mrg_err;
    logic [W_DATA-1:0]     lane_data;
    logic                  lane_err_any;
    logic [N_CHANNELS-1:0] start_vec;
    int unsigned           base;
    logic                  misalign;
    logic                  lock_hit;
    logic                  accept;
    logic                  emit;

`ifdef XGMII_BLK_ERR_CHECK_EN
    logic [N_CHANNELS-1:0] lane_err;

    xgmii_ctrl_checker #(
        .N_CHANNELS(N_CHANNELS)
    ) u_ctrl_checker (
        .i_data (i_xgmii_data),
        .i_ctrl (i_xgmii_ctrl),
        .o_data (lane_data),
        .o_err  (lane_err)
    );

    assign lane_err_any = |lane_err;
`else
    assign lane_data    = i_xgmii_data;
    assign lane_err_any = 1'b0;
`endif

    assign o_locked = (state == LOCKED);

    // START detection always uses raw lane data; positions are taken relative to transfer 0 when unlocked.
    always_comb begin
        misalign = 1'b0;
        lock_hit = 1'b0;
        base     = (state == LOCKED) ? 32'(cnt) * N_CHANNELS : 0;
        for (int unsigned n = 0; n < N_CHANNELS; n++) begin
            start_vec[n] = i_xgmii_ctrl[n] && (i_xgmii_data[8*n +: 8] == SYM_START);
            if (start_vec[n] && (base + n) != 0 && (base + n) != 4)
                misalign = 1'b1;
            if (start_vec[n] && (n == 0 || (N_CHANNELS == 8 && n == 4)))
                lock_hit = 1'b1;
        end
    end

    // A relock on a misaligned transfer restarts the block at slot 0 but never emits that cycle.
    always_comb begin
        accept  = i_valid && (lock_hit || (state == LOCKED && !misalign));
        wr_slot = (state == LOCKED && !misalign) ? cnt : '0;
        emit    = accept && !misalign && (wr_slot == LAST);
        cnt_nxt = (wr_slot == LAST) ? '0 : wr_slot + W_TRANS'(1);

        mrg = stg;
        mrg.data[wr_slot*W_DATA +: W_DATA]         = lane_data;
        mrg.ctrl[wr_slot*N_CHANNELS +: N_CHANNELS] = i_xgmii_ctrl;
        mrg_err = ((wr_slot == '0) ? 1'b0 : stg_err) | lane_err_any;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state          <= UNLOCKED;
            cnt            <= '0;
            stg            <= '0;
            stg_err        <= 1'b0;
            o_blk_data     <= '0;
            o_blk_ctrl     <= '0;
            o_blk_valid    <= 1'b0;
            o_blk_err      <= 1'b0;
            o_misalign_cnt <= '0;
        end else begin
            o_blk_valid <= emit;
            if (i_valid) begin
                if (misalign && o_misalign_cnt != 8'hFF)
                    o_misalign_cnt <= o_misalign_cnt + 8'd1;
                if (accept) begin
                    state   <= LOCKED;
                    cnt     <= cnt_nxt;
                    stg     <= mrg;
                    stg_err <= mrg_err;
                end else begin
                    state <= UNLOCKED;
                    cnt   <= '0;
                end
            end
            if (emit) begin
                o_blk_data <= mrg.data;
                o_blk_ctrl <= mrg.ctrl;
                o_blk_err  <= mrg_err;
            end
        end
    end

endmodule

// File: tb/tb_xgmii_blk_assembler.sv
// Directed self-checking bench for xgmii_blk_assembler at W_DATA = 16, 32 and 64.
// Expected error-byte handling follows XGMII_BLK_ERR_CHECK_EN.
module tb_xgmii_blk_assembler;

    logic clk;
    logic rst_n;

    logic [31:0] d32;  logic [3:0] c32;  logic v32;
    logic [15:0] d16;  logic [1:0] c16;  logic v16;
    logic [63:0] d64;  logic [7:0] c64;  logic v64;

    logic [63:0] bd32, bd16, bd64;
    logic [7:0]  bc32, bc16, bc64;
    logic        bv32, bv16, bv64;
    logic        be32, be16, be64;
    logic        lk32, lk16, lk64;
    logic [7:0]  mc32, mc16, mc64;

    int checks   = 0;
    int failures = 0;
    int pulses;

    xgmii_blk_assembler #(.W_DATA(32)) u32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_xgmii_data(d32), .i_xgmii_ctrl(c32), .i_valid(v32),
        .o_blk_data(bd32), .o_blk_ctrl(bc32), .o_blk_valid(bv32), .o_blk_err(be32),
        .o_locked(lk32), .o_misalign_cnt(mc32)
    );

    xgmii_blk_assembler #(.W_DATA(16)) u16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_xgmii_data(d16), .i_xgmii_ctrl(c16), .i_valid(v16),
        .o_blk_data(bd16), .o_blk_ctrl(bc16), .o_blk_valid(bv16), .o_blk_err(be16),
        .o_locked(lk16), .o_misalign_cnt(mc16)
    );

    xgmii_blk_assembler #(.W_DATA(64)) u64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_xgmii_data(d64), .i_xgmii_ctrl(c64), .i_valid(v64),
        .o_blk_data(bd64), .o_blk_ctrl(bc64), .o_blk_valid(bv64), .o_blk_err(be64),
        .o_locked(lk64), .o_misalign_cnt(mc64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        d32 = '0; c32 = '0; v32 = 1'b0;
        d16 = '0; c16 = '0; v16 = 1'b0;
        d64 = '0; c64 = '0; v64 = 1'b0;
        step();
        step();
        chk("rst_valid32", 64'(bv32), 0);
        chk("rst_data32",  bd32, 0);
        chk("rst_ctrl32",  64'(bc32), 0);
        chk("rst_err32",   64'(be32), 0);
        chk("rst_lock32",  64'(lk32), 0);
        chk("rst_mis32",   64'(mc32), 0);
        chk("rst_lock16",  64'(lk16), 0);
        chk("rst_valid64", 64'(bv64), 0);
        rst_n = 1'b1;

        // W=32 basic lock and first block
        v32 = 1'b1; d32 = 32'h555555FB; c32 = 4'h1;
        step();
        chk("lock32",     64'(lk32), 1);
        chk("nopulse32a", 64'(bv32), 0);
        d32 = 32'hD5555555; c32 = 4'h0;
        step();
        chk("pulse32a", 64'(bv32), 1);
        chk("data32a",  bd32, 64'hD5555555_555555FB);
        chk("ctrl32a",  64'(bc32), 8'h01);
        chk("err32a",   64'(be32), 0);
        v32 = 1'b0;
        step();
        chk("idle_nopulse32", 64'(bv32), 0);
        chk("hold_data32",    bd32, 64'hD5555555_555555FB);
        chk("hold_lock32",    64'(lk32), 1);

        // START at block position 4 is aligned
        v32 = 1'b1; d32 = 32'h07070707; c32 = 4'hF;
        step();
        chk("nopulse32b", 64'(bv32), 0);
        d32 = 32'h555555FB; c32 = 4'h1;
        step();
        chk("pulse32b", 64'(bv32), 1);
        chk("data32b",  bd32, 64'h555555FB_07070707);
        chk("ctrl32b",  64'(bc32), 8'h1F);
        chk("mis32b",   64'(mc32), 0);

        // START in lane 2 drops lock
        d32 = 32'h55FB5555; c32 = 4'h4;
        step();
        chk("unlock32",   64'(lk32), 0);
        chk("mis32c",     64'(mc32), 1);
        chk("nopulse32c", 64'(bv32), 0);
        d32 = 32'hD5555555; c32 = 4'h0;
        step();
        chk("nopulse32d", 64'(bv32), 0);
        chk("stay_unl32", 64'(lk32), 0);

        // misaligned START with a lane-0 START relocks on the same transfer
        d32 = 32'h555555FB; c32 = 4'h1;
        step();
        chk("relock32a", 64'(lk32), 1);
        d32 = 32'h55FB55FB; c32 = 4'h5;
        step();
        chk("mis32e",     64'(mc32), 2);
        chk("relock32b",  64'(lk32), 1);
        chk("nopulse32e", 64'(bv32), 0);
        d32 = 32'hAAAAAAAA; c32 = 4'h0;
        step();
        chk("pulse32e", 64'(bv32), 1);
        chk("data32e",  bd32, 64'hAAAAAAAA_55FB55FB);
        chk("ctrl32e",  64'(bc32), 8'h05);

        // illegal control byte 0x9C in lane 3
        d32 = 32'h9C5555FB; c32 = 4'h9;
        step();
        d32 = 32'h11223344; c32 = 4'h0;
        step();
        chk("pulse32f", 64'(bv32), 1);
`ifdef XGMII_BLK_ERR_CHECK_EN
        chk("data32f", bd32, 64'h11223344_FE5555FB);
        chk("err32f",  64'(be32), 1);
`else
        chk("data32f", bd32, 64'h11223344_9C5555FB);
        chk("err32f",  64'(be32), 0);
`endif
        chk("ctrl32f", 64'(bc32), 8'h09);
        v32 = 1'b0;

        // W=16 with i_valid toggling
        v16 = 1'b1; d16 = 16'h55FB; c16 = 2'b01;
        step();
        chk("nopulse16a", 64'(bv16), 0);
        v16 = 1'b0;
        step();
        v16 = 1'b1; d16 = 16'h5555; c16 = 2'b00;
        step();
        chk("nopulse16b", 64'(bv16), 0);
        v16 = 1'b0;
        step();
        v16 = 1'b1; d16 = 16'h6666;
        step();
        chk("nopulse16c", 64'(bv16), 0);
        v16 = 1'b0;
        step();
        chk("nopulse16d", 64'(bv16), 0);
        v16 = 1'b1; d16 = 16'hD577;
        step();
        chk("pulse16", 64'(bv16), 1);
        chk("data16",  bd16, 64'hD577_6666_5555_55FB);
        chk("ctrl16",  64'(bc16), 8'h01);
        v16 = 1'b0;
        step();
        chk("single16", 64'(bv16), 0);

        // W=64 lock emits immediately, then back-to-back IDLE blocks
        v64 = 1'b1; d64 = 64'hD5555555_555555FB; c64 = 8'h01;
        step();
        chk("pulse64a", 64'(bv64), 1);
        chk("data64a",  bd64, 64'hD5555555_555555FB);
        chk("lock64",   64'(lk64), 1);
        d64 = 64'h07070707_07070707; c64 = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_valid64", 64'(bv64), 1);
            chk("idle_ctrl64",  64'(bc64), 8'hFF);
            chk("idle_data64",  bd64, 64'h07070707_07070707);
        end
        d64 = 64'h07070707_0707FB07; c64 = 8'hFF;
        step();
        chk("mis_nopulse64", 64'(bv64), 0);
        chk("mis_unlock64",  64'(lk64), 0);
        chk("mis64",         64'(mc64), 1);
        v64 = 1'b0;

        // reset mid-block discards the partial block
        v32 = 1'b1; d32 = 32'h555555FB; c32 = 4'h1;
        step();
        chk("lock32g", 64'(lk32), 1);
        v32 = 1'b0; rst_n = 1'b0;
        step();
        chk("rst2_lock32",  64'(lk32), 0);
        chk("rst2_mis32",   64'(mc32), 0);
        chk("rst2_valid32", 64'(bv32), 0);
        chk("rst2_data32",  bd32, 0);
        chk("rst2_mis64",   64'(mc64), 0);
        rst_n = 1'b1;
        v32 = 1'b1; d32 = 32'hD5555555; c32 = 4'h0;
        step();
        chk("rst2_nopulse32", 64'(bv32), 0);
        chk("rst2_unl32",     64'(lk32), 0);
        v32 = 1'b0;

        // W=64 START in lane 4 locks
        v64 = 1'b1; d64 = 64'h555555FB_07070707; c64 = 8'h1F;
        step();
        chk("pulse64l4", 64'(bv64), 1);
        chk("data64l4",  bd64, 64'h555555FB_07070707);
        chk("ctrl64l4",  64'(bc64), 8'h1F);
        chk("lock64l4",  64'(lk64), 1);
        chk("mis64l4",   64'(mc64), 0);
        v64 = 1'b0;

        // 300 misaligned STARTs saturate the counter
        v32 = 1'b1; d32 = 32'h55FB5555; c32 = 4'h4;
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (bv32) pulses++;
        end
        chk("sat_pulses32", 64'(pulses), 0);
        chk("sat_mis32",    64'(mc32), 255);
        chk("sat_unl32",    64'(lk32), 0);
        v32 = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xgmii_blk_assembler.md
# xgmii_blk_assembler

Receive-side XGMII-to-block assembler for the 10G Ethernet datapath. It collects W_DATA-wide XGMII transfers into 64-bit blocks with 8 control flags, one per byte, ready for the 64b/66b encoder. It aligns block boundaries to the START symbol and generalises the fixed 32-bit XGMII assumption to 16-, 32- and 64-bit interfaces. It sits between the MAC-side XGMII and the encoder/gearbox.

## Interface
Parameters:
- W_DATA, 32, XGMII width in bits; legal values 16, 32, 64.
- N_CHANNELS, W_DATA/8, number of XGMII lanes; derived, not overridden.

Ports:
- i_clk  in  1  single clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_xgmii_data  in  W_DATA  lane n occupies bits [8n+7:8n].
- i_xgmii_ctrl  in  N_CHANNELS  1 = lane n carries a control symbol.
- i_valid  in  1  transfer qualifier; a transfer is ignored when low.
- o_blk_data  out  64  assembled block; byte 0 is the earliest.
- o_blk_ctrl  out  8  per-byte control flags.
- o_blk_valid  out  1  one-cycle pulse per block.
- o_blk_err  out  1  block contained an invalid control byte; qualified by o_blk_valid.
- o_locked  out  1  block alignment acquired.
- o_misalign_cnt  out  8  saturating count of misaligned STARTs.

## Operation
- N_TRANS = 64/W_DATA transfers make one block. The transfer counter cnt has width max(1, log2(N_TRANS)). Block byte position = cnt*N_CHANNELS + lane.
- The FSM has two states, UNLOCKED and LOCKED.
- UNLOCKED:
  - Nothing is emitted.
  - A valid transfer with ctrl[0]=1 and lane 0 = SYM_START (0xFB) is taken as transfer 0. The FSM moves to LOCKED and cnt goes to 1 mod N_TRANS.
  - With W_DATA=64, that transfer is emitted immediately.
  - With W_DATA=64, START in lane 4 also locks.
- LOCKED:
  - Each valid transfer is written into the staging register at cnt, and cnt increments.
  - When cnt wraps from N_TRANS-1 to 0, the block is emitted.
- Misalignment:
  - A START at any block position other than 0 or 4 is misaligned.
  - The partial block is dropped, the FSM goes to UNLOCKED, cnt clears, and o_misalign_cnt increments. It saturates at 255.
  - Re-acquisition is evaluated on the same transfer: a START in lane 0 relocks immediately.
- While LOCKED, idle streams keep being assembled. Lock is held across inter-frame gaps.
- i_valid low: no state change and no counter advance. Staging contents are held.
- o_blk_data, o_blk_ctrl and o_blk_err hold their last values between pulses.

## Timing
- Latency is 1 cycle: o_blk_valid is high in the cycle after the final transfer of a block is accepted.
- The maximum block rate is one per N_TRANS valid cycles. At W_DATA=64 this is one per cycle, back-to-back.
- Reset, sampled at the rising edge of i_clk with i_rst_n=0, sets:
  - state UNLOCKED, cnt 0, staging 0;
  - all outputs 0, including o_misalign_cnt.
- Reset in the middle of a block discards it, and no pulse is generated.
- A misaligned START on the final transfer of a block means no block is emitted for that cycle.

## Configuration
- Macro: XGMII_BLK_ERR_CHECK_EN.
- Defined:
  - Any byte with ctrl=1 whose value is not IDLE 0x07, START 0xFB, TERM 0xFD or ERR 0xFE is replaced by 0xFE in o_blk_data. Its ctrl flag stays 1.
  - o_blk_err=1 for that block.
- Undefined: control bytes pass through unchanged, and o_blk_err is tied 0.

## Structure
- cmn_params gains:
  - the N_TRANS/W_TRANS derivation extended to W_DATA=64, with width ≥1;
  - typedef blk_asm_state_t {UNLOCKED, LOCKED};
  - a packed struct blk_t {data[63:0], ctrl[7:0]}.
- Symbol constants stay in cmn_params.
- The per-lane validity check belongs in one combinational sub-module, xgmii_ctrl_checker (N_CHANNELS lanes). It is instantiated only under XGMII_BLK_ERR_CHECK_EN.

## Test plan
- W_DATA=32, first transfer data 0x555555FB ctrl 0001, then data 0xD5555555 ctrl 0000 -> o_locked=1 after transfer 1; one cycle after transfer 2, o_blk_valid=1, o_blk_data=0xD5555555_555555FB, o_blk_ctrl=0x01.
- W_DATA=32 locked, START at position 4 (transfer 1 lane 0) -> accepted, no misalign increment; START at lane 2 -> o_locked=0, partial dropped, o_misalign_cnt=1.
- W_DATA=16, i_valid toggling 1,0,1,0 across 4 transfers -> exactly one o_blk_valid, 1 cycle after the 4th valid transfer; data order preserved.
- W_DATA=64, continuous IDLE (0x07×8, ctrl 0xFF) after lock -> o_blk_valid high every cycle, o_blk_ctrl=0xFF.
- With XGMII_BLK_ERR_CHECK_EN defined, control byte 0x9C in lane 3 -> byte 3 output 0xFE, o_blk_err=1; without the macro -> 0x9C, o_blk_err=0.
- Assert i_rst_n=0 mid-block, then release and send 300 misaligned STARTs -> no output pulse; o_misalign_cnt reaches 255 and holds.
